apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 156 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB memory slave: word-addressed register memory with byte strobes,
// programmable wait states and out-of-range address error reporting.
//
// state  | meaning
// IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// ACCESS | setup latched; counting wait states until PREADY

module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Wait-state target, 4 bits to match the counter range 0-15.
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // DEPTH extended by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic [3:0] wcnt;
  logic [3:0] wcnt_next;

  logic                  setup;
  logic                  complete;
  logic                  addr_err;
  logic [IDX_W-1:0]      idx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Error and index are derived only from the latched address, so bus
  // activity during ACCESS cannot disturb the transfer in flight.
  assign addr_err = ({1'b0, addr_q} >= DEPTH_V);
  assign idx      = addr_q[IDX_W-1:0];

  // State and wait-counter registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Next-state logic and combinational bus outputs.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    setup      = 1'b0;
    complete   = 1'b0;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    PRDATA     = '0;

    case (state)
      IDLE: begin
        // PENABLE without a preceding setup is ignored here.
        if (PSEL && !PENABLE) begin
          setup      = 1'b1;
          wcnt_next  = 4'd0;
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        if (!PSEL || !PENABLE) begin
          // Master abandoned the transfer: no write, no PREADY.
          state_next = IDLE;
          wcnt_next  = 4'd0;
        end else if (wcnt < WS) begin
          wcnt_next = wcnt + 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
          wcnt_next  = 4'd0;
        end
      end

      default: begin
        state_next = IDLE;
        wcnt_next  = 4'd0;
      end
    endcase

    // Reset wins over everything on the bus.
    if (PRESET) begin
      complete = 1'b0;
    end

    PREADY  = complete;
    PSLVERR = complete && addr_err;
    if (complete && !write_q && !addr_err) begin
      PRDATA = mem[idx];
    end
  end

  // Capture the setup-phase request; held stable for the whole ACCESS phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      addr_q  <= PADDR;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Memory array: cleared on reset, byte-lane writes at transfer completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && write_q && !addr_err) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: directed vector table, hand-written
// abort/reset/back-to-back sequences and randomized transfers against a
// simple array model of the memory.

module tb_apb_mem_slave;

  localparam int WS    = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        preset;

  logic        psel, penable, pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic        psel0, penable0, pwrite0;
  logic [8:0]  paddr0;
  logic [31:0] pwdata0;
  logic [3:0]  pstrb0;
  logic [31:0] prdata0;
  logic        pready0, pslverr0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  apb_mem_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) u_dut (
    .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_mem_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(DEPTH), .WAIT_STATES(0)
  ) u_dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable0),
    .PWRITE(pwrite0), .PADDR(paddr0), .PWDATA(pwdata0), .PSTRB(pstrb0),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endfunction

  function automatic void model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int ai;
    ai = int'(a);
    if (ai < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[ai][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [8:0] a);
    int ai;
    ai = int'(a);
    return (ai < DEPTH) ? model_mem[ai] : 32'h0;
  endfunction

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
  endtask

  // One complete APB transfer on the WS=2 instance. Entered and left at
  // posedge+1. Bus inputs are scrambled during ACCESS to prove latching.
  task automatic xfer(input logic wr, input logic [8:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic err,
                      output int cycles);
    bit done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    check("setup_ready", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    penable = 1'b1;
    done = 0; cycles = 0; rd = 32'h0; err = 1'b0;
    while (!done && cycles < 20) begin
      cycles++;
      @(negedge clk);
      if (pready) begin
        rd = prdata; err = pslverr; done = 1;
      end else begin
        check("wait_slverr", {31'h0, pslverr}, 32'h0);
        check("wait_rdata", prdata, 32'h0);
      end
      @(posedge clk); #1;
      if (!done) begin
        paddr = 9'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pwrite = ~wr;
      end
    end
    bus_idle();
  endtask

  task automatic run_vec(input string tag, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          cyc;
    xfer(wr, a, d, s, rd, err, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(WS + 1));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_slverr"}, {31'h0, err}, {31'h0, exp_err});
    if (wr) model_write(a, d, s);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [8:0]  ra;
    logic [31:0] rdv;
    logic [3:0]  rs;
    logic        rw;

    vecs[0]  = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 9'h005, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h010, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 9'h010, 32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 9'h010, 32'h0,        4'h0, 32'h112233AA, 1'b0};
    vecs[5]  = '{1'b1, 9'h000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 9'h040, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 9'h040, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 9'h000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 9'h010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 9'h010, 32'h0,        4'h0, 32'h112233AA, 1'b0};
    vecs[11] = '{1'b1, 9'h03F, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 9'h03F, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
    vecs[13] = '{1'b0, 9'h1FF, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 9'h010, 32'hAABBCCDD, 4'hA, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 9'h010, 32'h0,        4'h0, 32'hAA22CCAA, 1'b0};

    bus_idle();
    psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0;
    paddr0 = '0; pwdata0 = '0; pstrb0 = '0;
    preset = 1'b1;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, pready}, 32'h0);
    check("rst_slverr", {31'h0, pslverr}, 32'h0);
    check("rst_rdata", prdata, 32'h0);
    check("rst_ready0", {31'h0, pready0}, 32'h0);
    @(posedge clk); #1;
    preset = 1'b0;

    // Directed table, back-to-back with no idle gap
    for (int i = 0; i < 16; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].strb, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // PENABLE without setup from IDLE is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h005; pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nosetup_ready", {31'h0, pready}, 32'h0);
      @(posedge clk); #1;
    end
    bus_idle();
    @(posedge clk); #1;
    run_vec("nosetup_rb", 1'b0, 9'h005, 32'h0, 4'h0, model_read(9'h005), 1'b0);

    // Abort by dropping PSEL in the 2nd access cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h03F; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abortA_ready1", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0;
    @(negedge clk);
    check("abortA_ready2", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    bus_idle();
    run_vec("abortA_rb", 1'b0, 9'h03F, 32'h0, 4'h0, model_read(9'h03F), 1'b0);

    // Abort by dropping PENABLE in the would-be completion cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h03F; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (WS) @(posedge clk);
    #1;
    penable = 1'b0;
    @(negedge clk);
    check("abortB_ready", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    run_vec("abortB_rb", 1'b0, 9'h03F, 32'h0, 4'h0, model_read(9'h03F), 1'b0);

    // Randomized transfers against the model
    for (int n = 0; n < 200; n++) begin
      rw  = 1'($urandom);
      ra  = 9'($urandom_range(0, 79));
      rdv = $urandom;
      rs  = 4'($urandom_range(0, 15));
      run_vec("rand", rw, ra, rdv, rs,
              rw ? 32'h0 : model_read(ra), (int'(ra) >= DEPTH));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset asserted mid-write to 0x01, with the bus still active
    run_vec("prerst_wr", 1'b1, 9'h001, 32'h13579BDF, 4'hF, 32'h0, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h001; pwdata = 32'h2468ACE0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_ready", {31'h0, pready}, 32'h0);
    check("midrst_slverr", {31'h0, pslverr}, 32'h0);
    check("midrst_rdata", prdata, 32'h0);
    @(posedge clk); #1;
    preset = 1'b0;
    bus_idle();
    model_clear();
    run_vec("postrst_rd01", 1'b0, 9'h001, 32'h0, 4'h0, 32'h0, 1'b0);
    run_vec("postrst_rd05", 1'b0, 9'h005, 32'h0, 4'h0, 32'h0, 1'b0);
    run_vec("postrst_rd3F", 1'b0, 9'h03F, 32'h0, 4'h0, 32'h0, 1'b0);

    // Zero-wait-state instance: back-to-back write/read, 2 cycles each
    psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; paddr0 = 9'h03F; pwdata0 = 32'hFFFFFFFF; pstrb0 = 4'hF;
    @(negedge clk);
    check("ws0_wr_setup", {31'h0, pready0}, 32'h0);
    @(posedge clk); #1;
    penable0 = 1'b1;
    @(negedge clk);
    check("ws0_wr_ready", {31'h0, pready0}, 32'h1);
    check("ws0_wr_slverr", {31'h0, pslverr0}, 32'h0);
    @(posedge clk); #1;
    penable0 = 1'b0; pwrite0 = 1'b0; pwdata0 = 32'h0;
    @(negedge clk);
    check("ws0_rd_setup", {31'h0, pready0}, 32'h0);
    @(posedge clk); #1;
    penable0 = 1'b1;
    @(negedge clk);
    check("ws0_rd_ready", {31'h0, pready0}, 32'h1);
    check("ws0_rd_data", prdata0, 32'hFFFFFFFF);
    @(posedge clk); #1;
    psel0 = 1'b0; penable0 = 1'b0;
    @(negedge clk);
    check("ws0_after_ready", {31'h0, pready0}, 32'h0);
    check("ws0_after_rdata", prdata0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
